crossover_signal_fsm: RTL and testbench

Registered trade-signal stage directly downstream of `moving_avg`. It consumes the SMA and EMA values once per price update and filters their crossover through a hysteresis deadband and a consecutive-sample confirmation counter. It commits a HOLD/BUY/SELL signal, counts trades, and optionally accumulates realized profit and loss (P&L) from the entry and exit prices. Its outputs drive LEDR[9:8] and the HEX5 signal-code decoder in place of the combinational comparator in `top`.

---
 rtl/crossover_signal_fsm.sv | 160 ++++++++++++++++
 tb/tb_crossover_signal_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/crossover_signal_fsm.sv
// rtl/crossover_signal_fsm.sv - SMA/EMA crossover filter committing HOLD/BUY/SELL with hysteresis and confirmation.
// Optional realized P&L tracking is compiled in with `define TRADE_PNL_EN.
module crossover_signal_fsm #(
  parameter int CONFIRM_N = 2,
  parameter int HYST      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  input  logic [7:0] sma,
  input  logic [7:0] ema,
  input  logic [3:0] price,
  output logic [1:0] signal,
  output logic [3:0] signal_code,
  output logic       trade_pulse,
  output logic [7:0] trade_count,
  output logic [9:0] pnl
);

  typedef enum logic [1:0] {
    SIG_HOLD = 2'b00,
    SIG_BUY  = 2'b01,
    SIG_SELL = 2'b10
  } sig_e;

  localparam logic [3:0]        CONF_MAX = 4'(CONFIRM_N);
  localparam logic signed [8:0] HYST_POS = 9'(HYST);
  localparam logic signed [8:0] HYST_NEG = 9'(-HYST);

  logic signed [8:0] diff;
  sig_e              cls;

  sig_e       cand_q, cand_d;
  sig_e       signal_q, signal_d;
  logic [3:0] conf_cnt_q, conf_cnt_d;
  logic       trade_pulse_q, trade_pulse_d;
  logic [7:0] trade_count_q, trade_count_d;
  logic       commit;

  assign diff = $signed({1'b0, sma}) - $signed({1'b0, ema});

  always_comb begin
    cls = SIG_HOLD;
    if (diff > HYST_POS) begin
      cls = SIG_BUY;
    end else if (diff < HYST_NEG) begin
      cls = SIG_SELL;
    end
  end

  // Commit is judged on the already-updated candidate and count, so it lands in the same cycle.
  always_comb begin
    cand_d        = cand_q;
    conf_cnt_d    = conf_cnt_q;
    signal_d      = signal_q;
    trade_pulse_d = 1'b0;
    trade_count_d = trade_count_q;
    commit        = 1'b0;
    if (sample_valid) begin
      if (cls == cand_q) begin
        if (conf_cnt_q < CONF_MAX) begin
          conf_cnt_d = conf_cnt_q + 4'd1;
        end
      end else begin
        cand_d     = cls;
        conf_cnt_d = 4'd1;
      end
      if ((conf_cnt_d == CONF_MAX) && (cand_d != signal_q)) begin
        commit   = 1'b1;
        signal_d = cand_d;
        if (cand_d != SIG_HOLD) begin
          trade_pulse_d = 1'b1;
          if (trade_count_q != 8'hFF) begin
            trade_count_d = trade_count_q + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q        <= SIG_HOLD;
      signal_q      <= SIG_HOLD;
      conf_cnt_q    <= 4'd0;
      trade_pulse_q <= 1'b0;
      trade_count_q <= 8'd0;
    end else begin
      cand_q        <= cand_d;
      signal_q      <= signal_d;
      conf_cnt_q    <= conf_cnt_d;
      trade_pulse_q <= trade_pulse_d;
      trade_count_q <= trade_count_d;
    end
  end

`ifdef TRADE_PNL_EN
  localparam logic signed [10:0] PNL_MAX = 11'sd511;
  localparam logic signed [10:0] PNL_MIN = -11'sd512;

  logic [3:0]         entry_price_q, entry_price_d;
  logic signed [9:0]  pnl_q, pnl_d;
  logic signed [4:0]  delta;
  logic signed [10:0] pnl_sum;

  // A direct BUY<->SELL flip closes against the old entry and re-opens at the current price.
  always_comb begin
    entry_price_d = entry_price_q;
    delta         = 5'sd0;
    if (commit) begin
      if (signal_q == SIG_BUY) begin
        delta = $signed({1'b0, price}) - $signed({1'b0, entry_price_q});
      end else if (signal_q == SIG_SELL) begin
        delta = $signed({1'b0, entry_price_q}) - $signed({1'b0, price});
      end
      if (signal_d != SIG_HOLD) begin
        entry_price_d = price;
      end
    end
    pnl_sum = $signed({pnl_q[9], pnl_q}) + $signed({{6{delta[4]}}, delta});
    if (pnl_sum > PNL_MAX) begin
      pnl_d = 10'sh1FF;
    end else if (pnl_sum < PNL_MIN) begin
      pnl_d = 10'sh200;
    end else begin
      pnl_d = pnl_sum[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_price_q <= 4'd0;
      pnl_q         <= 10'sd0;
    end else begin
      entry_price_q <= entry_price_d;
      pnl_q         <= pnl_d;
    end
  end

  assign pnl = pnl_q;
`else
  logic unused_pnl_inputs;
  assign unused_pnl_inputs = ^{commit, price};
  assign pnl               = 10'd0;
`endif

  always_comb begin
    signal_code = 4'd1;
    case (signal_q)
      SIG_BUY:  signal_code = 4'd2;
      SIG_SELL: signal_code = 4'd3;
      default:  signal_code = 4'd1;
    endcase
  end

  assign signal      = signal_q;
  assign trade_pulse = trade_pulse_q;
  assign trade_count = trade_count_q;

endmodule

// File: tb/tb_crossover_signal_fsm.sv
// tb/tb_crossover_signal_fsm.sv - scoreboard bench for crossover_signal_fsm (CONFIRM_N=2 and CONFIRM_N=1 instances).
module tb_crossover_signal_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_valid;
  logic [7:0] sma, ema;
  logic [3:0] price;

  logic [1:0] sig0, sig1;
  logic [3:0] code0, code1;
  logic       pulse0, pulse1;
  logic [7:0] cnt0, cnt1;
  logic [9:0] pnl0, pnl1;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef TRADE_PNL_EN
  localparam bit PNL_ON = 1'b1;
`else
  localparam bit PNL_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  crossover_signal_fsm #(.CONFIRM_N(2), .HYST(1)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .sma(sma), .ema(ema), .price(price),
    .signal(sig0), .signal_code(code0), .trade_pulse(pulse0),
    .trade_count(cnt0), .pnl(pnl0)
  );

  crossover_signal_fsm #(.CONFIRM_N(1), .HYST(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .sma(sma), .ema(ema), .price(price),
    .signal(sig1), .signal_code(code1), .trade_pulse(pulse1),
    .trade_count(cnt1), .pnl(pnl1)
  );

  typedef struct {
    int         which;
    logic [1:0] sig;
    logic       pulse;
    logic [7:0] cnt;
    logic [9:0] pnl;
  } exp_t;

  exp_t exp_q[$];

  int m_n[2] = '{2, 1};
  int m_cand[2], m_cnt[2], m_sig[2], m_trades[2], m_pnl[2], m_entry[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cand[i] = 0; m_cnt[i] = 0; m_sig[i] = 0;
      m_trades[i] = 0; m_pnl[i] = 0; m_entry[i] = 0;
    end
  endtask

  // Reference behaviour: 0=HOLD, 1=BUY, 2=SELL.
  task automatic model_step(input int s, input int e, input int p);
    int   d, c;
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      d = s - e;
      c = (d > 1) ? 1 : ((d < -1) ? 2 : 0);
      if (c == m_cand[i]) m_cnt[i] = (m_cnt[i] + 1 > m_n[i]) ? m_n[i] : m_cnt[i] + 1;
      else begin m_cand[i] = c; m_cnt[i] = 1; end
      x.pulse = 1'b0;
      if (m_cnt[i] == m_n[i] && m_cand[i] != m_sig[i]) begin
        if (m_sig[i] == 1) m_pnl[i] += p - m_entry[i];
        if (m_sig[i] == 2) m_pnl[i] += m_entry[i] - p;
        if (m_pnl[i] > 511) m_pnl[i] = 511;
        if (m_pnl[i] < -512) m_pnl[i] = -512;
        if (m_cand[i] != 0) begin
          m_entry[i] = p;
          x.pulse = 1'b1;
          if (m_trades[i] < 255) m_trades[i]++;
        end
        m_sig[i] = m_cand[i];
      end
      x.which = i;
      x.sig   = 2'(m_sig[i]);
      x.cnt   = 8'(m_trades[i]);
      x.pnl   = PNL_ON ? 10'(m_pnl[i]) : 10'd0;
      exp_q.push_back(x);
    end
  endtask

  task automatic drain_scoreboard();
    exp_t       x;
    logic [1:0] gs;
    logic [3:0] gc;
    logic       gp;
    logic [7:0] gn;
    logic [9:0] gl;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (x.which == 0) begin gs = sig0; gc = code0; gp = pulse0; gn = cnt0; gl = pnl0; end
      else begin gs = sig1; gc = code1; gp = pulse1; gn = cnt1; gl = pnl1; end
      check_eq($sformatf("signal%0d", x.which), 32'(gs), 32'(x.sig));
      check_eq($sformatf("code%0d", x.which), 32'(gc), 32'(x.sig) + 32'd1);
      check_eq($sformatf("pulse%0d", x.which), 32'(gp), 32'(x.pulse));
      check_eq($sformatf("count%0d", x.which), 32'(gn), 32'(x.cnt));
      check_eq($sformatf("pnl%0d", x.which), 32'(gl), 32'(x.pnl));
    end
  endtask

  task automatic strobe(input int s, input int e, input int p, input bit gap);
    sma = 8'(s); ema = 8'(e); price = 4'(p);
    sample_valid = 1'b1;
    model_step(s, e, p);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    sma = 8'($urandom); ema = 8'($urandom); price = 4'($urandom);
    drain_scoreboard();
    if (gap) begin
      @(posedge clk); #1;
      check_eq("pulse_drop0", 32'(pulse0), 32'd0);
      check_eq("pulse_drop1", 32'(pulse1), 32'd0);
      check_eq("hold_idle0", 32'(sig0), 32'(m_sig[0]));
      check_eq("hold_idle1", 32'(sig1), 32'(m_sig[1]));
    end
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    for (int k = 0; k < ncyc; k++) begin
      sample_valid = ~sample_valid;
      sma = 8'd200; ema = 8'd3; price = 4'd9;
      @(posedge clk); #1;
      check_eq("rst_signal0", 32'(sig0), 32'd0);
      check_eq("rst_code0", 32'(code0), 32'd1);
      check_eq("rst_pulse0", 32'(pulse0), 32'd0);
      check_eq("rst_count0", 32'(cnt0), 32'd0);
      check_eq("rst_pnl0", 32'(pnl0), 32'd0);
      check_eq("rst_signal1", 32'(sig1), 32'd0);
      check_eq("rst_count1", 32'(cnt1), 32'd0);
    end
    sample_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; sma = 8'd0; ema = 8'd0; price = 4'd0;
    @(posedge clk); #1;
    do_reset(3);

    strobe(10, 5, 4, 1);
    check_eq("buy_first_hold", 32'(sig0), 32'd0);
    strobe(10, 5, 4, 1);
    check_eq("buy_commit", 32'(sig0), 32'd1);
    check_eq("buy_count", 32'(cnt0), 32'd1);

    strobe(6, 5, 4, 1);
    strobe(6, 5, 4, 1);
    check_eq("deadband_hold", 32'(sig0), 32'd0);
    check_eq("deadband_count", 32'(cnt0), 32'd1);

    do_reset(1);
    strobe(10, 5, 2, 1);
    strobe(5, 10, 6, 1);
    strobe(10, 5, 3, 1);
    strobe(5, 10, 8, 1);
    check_eq("chatter_hold", 32'(sig0), 32'd0);
    check_eq("chatter_count", 32'(cnt0), 32'd0);

    do_reset(1);
    strobe(10, 5, 4, 1);
    strobe(10, 5, 4, 1);
    strobe(5, 10, 9, 1);
    strobe(5, 10, 9, 1);
    check_eq("pnl_sell", 32'(pnl0), PNL_ON ? 32'd5 : 32'd0);
    check_eq("pnl_sell_count", 32'(cnt0), 32'd2);
    strobe(5, 5, 7, 1);
    strobe(5, 5, 7, 1);
    check_eq("pnl_hold", 32'(pnl0), PNL_ON ? 32'd7 : 32'd0);

    do_reset(1);
    for (int k = 0; k < 260; k++) begin
      if (k % 2 == 0) strobe(10, 5, 0, 0);
      else            strobe(5, 10, 15, 0);
    end
    check_eq("count_sat", 32'(cnt1), 32'd255);
    check_eq("pnl_sat_pos", 32'(pnl1), PNL_ON ? 32'h1FF : 32'd0);

    do_reset(1);
    for (int k = 0; k < 80; k++) begin
      if (k % 2 == 0) strobe(10, 5, 15, 0);
      else            strobe(5, 10, 0, 0);
    end
    check_eq("pnl_sat_neg", 32'(pnl1), PNL_ON ? 32'h200 : 32'd0);

    do_reset(1);
    strobe(10, 5, 3, 1);
    do_reset(1);
    strobe(10, 5, 3, 1);
    check_eq("midreset_hold", 32'(sig0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
